seq_serializer: RTL and testbench
=================================

# seq_serializer

Parallel-to-serial front end for the sequence-detector chain. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `x`, which feeds the serial `x` input of the downstream Mealy 101 detector. Back-to-back words produce a gap-free bitstream, and a stall input freezes the stream without losing bits.

## Interface
- `WIDTH`, default 8: bits per word, must be ≥ 2.
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-low reset.
- `in_data`  input  WIDTH: word to serialize; sampled on an accepted handshake.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: the block can accept a word this cycle. Combinational from state; `in_valid` must not depend combinationally on `in_ready`.
- `stall`  input  1: freeze shifting while high.
- `x`  output  1: serial bit to the detector; registered.
- `x_valid`  output  1: `x` carries a real data bit this cycle.
- `frame_end`  output  1: the current `x` is the last bit of its word.
- `busy`  output  1: a word is in flight (high in SHIFT).

## Operation
- State machine has two states: IDLE and SHIFT. It also holds a WIDTH-bit shift register `sr` and a bit counter `cnt` of width $clog2(WIDTH), range 0..WIDTH-1.
- Accept condition: `in_valid & in_ready` at a rising edge.
- `in_ready` is high when the block is in IDLE, or when it is in SHIFT with `cnt == WIDTH-1` and `stall == 0`.
- In IDLE:
  - `x = 0`, `x_valid = 0`, `frame_end = 0`.
  - On accept: `sr <= in_data`, `cnt <= 0`, go to SHIFT.
- In SHIFT:
  - `x` is the current output bit of `sr` (MSB, or LSB under the config macro).
  - `x_valid = 1`; `frame_end = (cnt == WIDTH-1)`.
- SHIFT edge, `stall = 1`: `sr`, `cnt` and state all hold, and `x` repeats. `x_valid` stays 1; the downstream stage qualifies with `!stall`.
- SHIFT edge, `stall = 0`, `cnt < WIDTH-1`: shift `sr` by one toward the output end, `cnt <= cnt + 1`.
- SHIFT edge, `stall = 0`, `cnt == WIDTH-1`:
  - With accept: reload `sr <= in_data`, `cnt <= 0`, stay in SHIFT (seamless).
  - Without accept: go to IDLE.
- In IDLE, `in_data` and `stall` are ignored unless an accept occurs; `stall` has no effect in IDLE.
- `in_data` is captured only on accept; changes afterwards do not affect the word in flight.

## Timing
- Reset (`reset == 0`, asynchronous): state = IDLE, `sr = 0`, `cnt = 0`. Outputs go to `x = 0`, `x_valid = 0`, `frame_end = 0`, `busy = 0`, `in_ready = 1`.
- Reset asserted mid-word aborts the word immediately; no partial bits appear after `reset` deasserts.
- Latency: accept at edge k puts the first bit on `x` after edge k. Bit i is valid in cycle k+i, so the word spans cycles k..k+WIDTH-1 when there are no stalls.
- Throughput is one bit per unstalled cycle. Back-to-back words have zero idle cycles between them.
- Each stall cycle extends the word by one cycle.
- A stall on the last bit blocks acceptance; `in_ready` stays low that cycle.

## Configuration
- `SER_LSB_FIRST_EN`
  - Defined: `x` starts at `sr[0]` and `sr` shifts right, so the word goes out LSB first.
  - Undefined (default): `x` starts at `sr[WIDTH-1]` and `sr` shifts left, so the word goes out MSB first.
  - Handshake, counter and timing are identical in both builds.

## Test plan
- Reset, then accept 8'hA5 (MSB build) → `x` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, `x_valid` = 1 throughout, `frame_end` high only on the 8th bit, then return to IDLE with `x = 0`.
- Back-to-back: 8'hA5 then 8'h0F, with `in_valid` held → 16 contiguous valid bits 10100101 00001111, and `in_ready` pulses on the last bit of the first word.
- Stall of 2 cycles asserted during bit 3 of 8'hA5 → bit 3 is held for 3 cycles in total, the word takes 10 cycles, and no bit is lost or duplicated once stall is qualified out.
- `reset` pulled low during bit 4 → `x`, `x_valid`, `busy` go to 0 asynchronously and `in_ready = 1`; after release, a new word 8'hFF serializes cleanly.
- `SER_LSB_FIRST_EN` defined, WIDTH=3, word 3'b110 → `x` = 0,1,1. Fed to the detector, a word stream producing 1,0,1 yields exactly one `z` pulse.
- Handshake corner: stall held high on the last bit while `in_valid = 1` → no accept until stall drops, then the next word starts on the following cycle.

Source files
------------

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial front end feeding the serial x input of the sequence detector.
// Optional build macro SER_LSB_FIRST_EN: word leaves LSB first instead of MSB first.
module seq_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             x,
  output logic             x_valid,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, sr_n, sr_shifted;
  logic [CW-1:0]    cnt, cnt_n;
  logic             accept;
  logic             x_n;

  assign in_ready = (state == IDLE) || ((cnt == LAST) && !stall);
  assign accept   = in_valid && in_ready;

`ifdef SER_LSB_FIRST_EN
  assign sr_shifted = {1'b0, sr[WIDTH-1:1]};
  assign x_n        = sr_n[0];
`else
  assign sr_shifted = {sr[WIDTH-2:0], 1'b0};
  assign x_n        = sr_n[WIDTH-1];
`endif

  always_comb begin
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          sr_n    = in_data;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (!stall) begin
          if (cnt != LAST) begin
            sr_n  = sr_shifted;
            cnt_n = cnt + CW'(1);
          end else if (accept) begin
            sr_n  = in_data;
            cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so x/x_valid/frame_end line up with sr and cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      x         <= (state_n == SHIFT) && x_n;
      x_valid   <= (state_n == SHIFT);
      frame_end <= (state_n == SHIFT) && (cnt_n == LAST);
      busy      <= (state_n == SHIFT);
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// tb/tb_seq_serializer.sv - directed self-checking bench for seq_serializer (default MSB-first build, WIDTH=8).
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       stall;
  logic       x;
  logic       x_valid;
  logic       frame_end;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  seq_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .stall     (stall),
    .x         (x),
    .x_valid   (x_valid),
    .frame_end (frame_end),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_x_valid"}, 32'(x_valid), 0);
    chk({tag, "_frame_end"}, 32'(frame_end), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  initial begin
    logic [15:0] stream;
    logic [7:0]  word;
    logic [7:0]  got;
    int          hold_idx [10];

    reset    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    stall    = 1'b0;
    #12;
    chk_idle("reset");
    reset = 1'b1;
    tick();
    chk_idle("post_reset");

    // Single word A5, MSB first
    word = 8'hA5;
    send(word);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_x%0d", i), 32'(x), 32'(word[7-i]));
      chk($sformatf("a5_xv%0d", i), 32'(x_valid), 1);
      chk($sformatf("a5_fe%0d", i), 32'(frame_end), 32'(i == 7));
      tick();
    end
    chk_idle("a5_done");

    // Back-to-back A5 then 0F with in_valid held
    stream   = 16'hA50F;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_data = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_x%0d", i), 32'(x), 32'(stream[15-i]));
      chk($sformatf("b2b_xv%0d", i), 32'(x_valid), 1);
      chk($sformatf("b2b_rdy%0d", i), 32'(in_ready), 32'(i == 7 || i == 15));
      tick();
      if (i == 7) in_valid = 1'b0;
    end
    chk_idle("b2b_done");

    // Two-cycle stall during bit 3 of A5
    word = 8'hA5;
    hold_idx = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
    got = 8'h00;
    send(word);
    for (int c = 0; c < 10; c++) begin
      stall = (c == 3 || c == 4);
      chk($sformatf("stall_x%0d", c), 32'(x), 32'(word[7-hold_idx[c]]));
      chk($sformatf("stall_fe%0d", c), 32'(frame_end), 32'(c == 9));
      if (x_valid && !stall) got = {got[6:0], x};
      tick();
    end
    stall = 1'b0;
    chk("stall_word", 32'(got), 32'h0000_00A5);
    chk_idle("stall_done");

    // Asynchronous reset during bit 4
    send(8'hA5);
    repeat (4) tick();
    chk("rst_busy_before", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk_idle("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_idle("rst_release");
    send(8'hFF);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ff_x%0d", i), 32'(x), 1);
      chk($sformatf("ff_fe%0d", i), 32'(frame_end), 32'(i == 7));
      tick();
    end
    chk_idle("ff_done");

    // Stall on the last bit blocks acceptance of the next word
    word     = 8'h3C;
    in_data  = 8'h81;
    in_valid = 1'b1;
    tick();
    in_data = word;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("hs_rdy%0d", i), 32'(in_ready), 0);
      tick();
    end
    stall = 1'b1;
    #1;
    chk("hs_stall_rdy0", 32'(in_ready), 0);
    chk("hs_stall_fe0", 32'(frame_end), 1);
    chk("hs_stall_x0", 32'(x), 1);
    tick();
    chk("hs_stall_rdy1", 32'(in_ready), 0);
    chk("hs_stall_fe1", 32'(frame_end), 1);
    chk("hs_stall_x1", 32'(x), 1);
    stall = 1'b0;
    #1;
    chk("hs_release_rdy", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("hs_x%0d", i), 32'(x), 32'(word[7-i]));
      chk($sformatf("hs_busy%0d", i), 32'(busy), 1);
      chk($sformatf("hs_fe%0d", i), 32'(frame_end), 32'(i == 7));
      tick();
    end
    chk_idle("hs_done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
